// File: rtl/conv3x3_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_sequencer
// Purpose  : Frame-level controller for a 3x3 convolution kernel. Accepts
//            image columns (three vertically adjacent pixels per beat) over a
//            valid/ready stream, drives the kernel shift and column inputs,
//            holds the nine 8-bit weights and forwards one 16-bit result per
//            fully populated window over a valid/ready stream with row/column
//            tags.
// Ports    : CLK, RESET (async, active high)
//            start / busy / done            frame control and status
//            cfg_we / cfg_addr / cfg_wdata  weight programming (IDLE only)
//            col_valid / col_ready / col_*  column input stream
//            k_shift / k_in_* / k_w         kernel drive
//            k_out_val                      kernel result (combinational)
//            pix_valid / pix_ready / pix_*  result output stream
// Revision : 1.0 - initial release
// ============================================================================
module conv3x3_sequencer #(
   parameter int IMG_W    = 32,
   parameter int OUT_ROWS = 30,
   parameter int CW       = 6
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic          cfg_we,
   input  logic [3:0]    cfg_addr,
   input  logic [7:0]    cfg_wdata,
   input  logic          col_valid,
   output logic          col_ready,
   input  logic [7:0]    col_a,
   input  logic [7:0]    col_b,
   input  logic [7:0]    col_c,
   output logic          k_shift,
   output logic [7:0]    k_in_a,
   output logic [7:0]    k_in_b,
   output logic [7:0]    k_in_c,
   output logic [71:0]   k_w,
   input  logic [15:0]   k_out_val,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic [15:0]   pix_data,
   output logic [CW-1:0] pix_row,
   output logic [CW-1:0] pix_col
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0] c_last_col = CW'(IMG_W - 1);
   localparam logic [CW-1:0] c_last_row = CW'(OUT_ROWS - 1);
   localparam logic [CW-1:0] c_fill     = CW'(2);
   localparam logic [CW-1:0] c_one      = CW'(1);
   localparam logic [CW-1:0] c_zero     = '0;

   state_t        r_state;
   logic [CW-1:0] r_col_cnt;
   logic [CW-1:0] r_row_cnt;
   logic [7:0]    r_w [0:8];
   logic          r_busy;
   logic          r_done;

   logic          w_run;
   logic          w_win;
   logic          w_beat;

   // A window exists only once two earlier columns of the same row have been
   // shifted in; the first two beats of every row just refill the taps.
   assign w_run  = (r_state == S_RUN);
   assign w_win  = (r_col_cnt >= c_fill);
   assign w_beat = col_valid & col_ready;

   // Zero-latency handshake: the column that completes a window is consumed
   // in the same cycle its result is accepted, so backpressure on the result
   // stream stalls the column stream directly.
   assign pix_valid = w_run & col_valid & w_win;
   assign col_ready = w_run & (~w_win | pix_ready);
   assign k_shift   = w_beat;

   assign k_in_a   = col_a;
   assign k_in_b   = col_b;
   assign k_in_c   = col_c;
   assign pix_data = k_out_val;
   assign pix_row  = r_row_cnt;
   assign pix_col  = r_col_cnt - c_fill;

   assign busy = r_busy;
   assign done = r_done;

   for (genvar gi = 0; gi < 9; gi++) begin : g_kw
      assign k_w[8*gi +: 8] = r_w[gi];
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state   <= S_IDLE;
         r_col_cnt <= c_zero;
         r_row_cnt <= c_zero;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            r_w[i] <= 8'd0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               // Weights are writable only between frames.
               if (cfg_we && (cfg_addr < 4'd9)) begin
                  r_w[cfg_addr] <= cfg_wdata;
               end
               if (start) begin
                  r_state   <= S_RUN;
                  r_col_cnt <= c_zero;
                  r_row_cnt <= c_zero;
                  r_busy    <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_beat) begin
                  if (r_col_cnt == c_last_col) begin
                     r_col_cnt <= c_zero;
                     if (r_row_cnt == c_last_row) begin
                        r_row_cnt <= c_zero;
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                     end else begin
                        r_row_cnt <= r_row_cnt + c_one;
                     end
                  end else begin
                     r_col_cnt <= r_col_cnt + c_one;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
